// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The top level is configured with the INSTR_FETCH_BYPASS_EN macro.
package instr_fetch_queue_pkg;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int ENTRY_W = XLEN + ILEN;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// In-order storage for fetched {pc, instr} entries with a single-cycle flush.
// Callers guarantee no push when full and no pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage is reset because the head drives out_pc/out_instr
  // directly and those must read zero out of reset; a flush leaves it intact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch unit: issues word reads, queues {pc, instr} for decode, flushes on redirect.
// Define INSTR_FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;
  logic            r_drop;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occupancy;
  logic            w_fifo_empty;
  logic            w_issue;
  logic            w_resp_valid;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // Outstanding requests reserve a slot so a response never finds the queue full.
  assign w_occupancy  = {1'b0, w_count} + (CW + 1)'(r_inflight);
  assign w_fifo_empty = (w_count == '0);
  assign w_issue      = rst_n && !redirect_valid && (w_occupancy < DEPTH_W);
  assign w_resp_valid = rst_n && r_inflight && !r_drop && !redirect_valid;

`ifdef INSTR_FETCH_BYPASS_EN
  assign w_bypass = w_fifo_empty && w_resp_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push       = w_resp_valid && !(w_bypass && out_ready);
  assign w_pop        = rst_n && !w_fifo_empty && out_ready && !redirect_valid;
  assign w_push_entry = '{pc: r_inflight_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      // Marks any response still owed to the pre-flush stream as stale.
      r_drop     <= redirect_valid;
      if (redirect_valid) begin
        r_fetch_pc <= word_align(redirect_pc);
      end else if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign imem_req  = w_issue;
  assign imem_addr = r_fetch_pc;
  assign out_valid = rst_n && (!w_fifo_empty || w_bypass);
  assign out_pc    = w_bypass ? r_inflight_pc : w_head.pc;
  assign out_instr = w_bypass ? imem_rdata    : w_head.instr;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Table-driven bench for instr_fetch_queue with a one-cycle-latency memory model.
// Expectations follow INSTR_FETCH_BYPASS_EN when the bench is built with it.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic        chk_addr;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy,
                              logic e_req, logic ca, logic [31:0] e_addr,
                              logic e_val, logic [31:0] e_pc);
    vec_t v;
    v.rst_n = r;  v.rv = rv;  v.rpc = rpc;  v.rdy = rdy;
    v.e_req = e_req;  v.chk_addr = ca;  v.e_addr = e_addr;
    v.e_val = e_val;  v.e_pc = e_pc;
    return v;
  endfunction

  // Memory contents: a distinct word per address (0x0 -> NOP 0x13).
  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a + 32'h0000_0013;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; the memory answers a request on the following cycle.
  task automatic tick();
    logic        req;
    logic [31:0] addr;
    req  = imem_req;
    addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = req ? instr_of(addr) : 32'hDEAD_BEEF;
    @(negedge clk);
  endtask

  task automatic drive(logic r, logic rv, logic [31:0] rpc, logic rdy);
    rst_n          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  initial begin
    int n_req;
    imem_rdata = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

`ifndef INSTR_FETCH_BYPASS_EN
    // reset
    vecs.push_back(mk(0,0,32'h0,0,       0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,       0,1,32'h0,        0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,       0,1,32'h0,        0,32'h0));
    // streaming, head at N+2
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h4,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h8,        1,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'hC,        1,32'h4));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h10,       1,32'h8));
    // reset mid-stream drops queue and in-flight 0x10
    vecs.push_back(mk(0,0,32'h0,1,       0,0,32'h0,        0,32'h0));
    // backpressure: four requests then stall
    vecs.push_back(mk(1,0,32'h0,0,       1,1,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,0,       1,1,32'h4,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,0,       1,1,32'h8,        1,32'h0));
    vecs.push_back(mk(1,0,32'h0,0,       1,1,32'hC,        1,32'h0));
    vecs.push_back(mk(1,0,32'h0,0,       0,1,32'h10,       1,32'h0));
    vecs.push_back(mk(1,0,32'h0,0,       0,1,32'h10,       1,32'h0));
    vecs.push_back(mk(1,0,32'h0,0,       0,1,32'h10,       1,32'h0));
    // drain in order, fetch resumes at 0x10
    vecs.push_back(mk(1,0,32'h0,1,       0,1,32'h10,       1,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h10,       1,32'h4));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h14,       1,32'h8));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h18,       1,32'hC));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h1C,       1,32'h10));
    // redirect to 0x103 while 0x1C response arrives; 0x14 pop is cancelled
    vecs.push_back(mk(1,1,32'h103,1,     0,1,32'h20,       1,32'h14));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h100,      0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h104,      0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h108,      1,32'h100));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h10C,      1,32'h104));
    // back-to-back redirects, last wins, then address wrap
    vecs.push_back(mk(1,1,32'h500,1,     0,1,32'h110,      1,32'h108));
    vecs.push_back(mk(1,1,32'hFFFF_FFFC,1, 0,1,32'h500,    0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'hFFFF_FFFC,0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h4,        1,32'hFFFF_FFFC));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h8,        1,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'hC,        1,32'h4));
`else
    vecs.push_back(mk(0,0,32'h0,0,       0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,       0,1,32'h0,        0,32'h0));
    // head visible at N+1 via bypass, consumed without queuing
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h4,        1,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h8,        1,32'h4));
    // redirect: 0x8 discarded, redirect target visible at R+2
    vecs.push_back(mk(1,1,32'h200,1,     0,1,32'hC,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h200,      0,32'h0));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h204,      1,32'h200));
    // bypassed entry not taken is written and stays at the head
    vecs.push_back(mk(1,0,32'h0,0,       1,1,32'h208,      1,32'h204));
    vecs.push_back(mk(1,0,32'h0,0,       1,1,32'h20C,      1,32'h204));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h210,      1,32'h204));
    vecs.push_back(mk(1,0,32'h0,1,       1,1,32'h214,      1,32'h208));
`endif

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      #1;
      check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].chk_addr)
        check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_val));
      if (vecs[i].e_val) begin
        check($sformatf("row%0d out_pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("row%0d out_instr", i), out_instr, instr_of(vecs[i].e_pc));
      end
      tick();
    end

    // Full boundary: with decode stalled, exactly DEPTH requests go out.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    n_req = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      if (imem_req) n_req++;
      tick();
    end
    check("stall request count", 32'(n_req), 32'd4);
    check("stall head pc", out_pc, 32'h0);
    check("stall head valid", 32'(out_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
